pipe_hazard_ctrl: RTL

//  Central pipeline control for the 5-stage MIPS core. Detects load-use hazards
//  on the decode-stage load destination (d_dstM, registered into E as E_dstM) and

---
 rtl/pipe_hazard_ctrl_pkg.sv | 26 ++
 rtl/pipe_hazard_ctrl_timer.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared opcode constants, FSM state encoding and decode helpers for pipe_hazard_ctrl.
package pipe_hazard_ctrl_pkg;

  localparam logic [5:0] IROP  = 6'b000000;
  localparam logic [5:0] IADDI = 6'b001000;
  localparam logic [5:0] ILW   = 6'b100011;
  localparam logic [5:0] ISW   = 6'b101011;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_ERROR   = 2'd2
  } state_e;

  // rt is read as a source only by R-type ops and stores
  function automatic logic rt_is_src(input logic [5:0] op);
    logic r;
    case (op)
      IROP, ISW:  r = 1'b1;
      ILW, IADDI: r = 1'b0;
      default:    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_timer.sv
// mem_wait_timer: counts consecutive data-memory wait cycles and flags TIMEOUT.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CW      = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic inc_i,
  input  logic clear_i,
  output logic expired_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)      cnt_d = '0;
    else if (start_i) cnt_d = CW'(1);
    else if (inc_i)   cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == CW'(TIMEOUT));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/bubble control: load-use, branch flush, memory wait and timeout halt.
// Optional PIPE_HAZARD_CTRL_PERF_EN adds stall_cycles/flush_cnt counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CW      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] D_op,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [4:0] E_dstM,
  input  logic       E_br_taken,
  input  logic       M_memop,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       F_stall,
  output logic       D_stall,
  output logic       D_bubble,
  output logic       E_bubble,
  output logic       M_stall,
  output logic       W_bubble,
  output logic       halt
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_cnt
`endif
);

  state_e state_q, state_d;
  logic   tmr_start, tmr_inc, tmr_clear, tmr_expired;
  logic   mem_hold, load_use, flush;

  mem_wait_timer #(
    .TIMEOUT(TIMEOUT),
    .CW     (CW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (tmr_start),
    .inc_i    (tmr_inc),
    .clear_i  (tmr_clear),
    .expired_o(tmr_expired)
  );

  assign load_use = (E_dstM != '0) &&
                    ((E_dstM == D_rs) || ((E_dstM == D_rt) && rt_is_src(D_op)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    tmr_start = 1'b0;
    tmr_inc   = 1'b0;
    tmr_clear = 1'b0;
    mem_hold  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (M_memop && !mem_ready) begin
          mem_hold  = 1'b1;
          tmr_start = 1'b1;
          state_d   = ST_MEMWAIT;
        end
      end
      ST_MEMWAIT: begin
        if (mem_ready) begin
          tmr_clear = 1'b1;
          state_d   = ST_RUN;
        end else begin
          mem_hold = 1'b1;
          if (tmr_expired) state_d = ST_ERROR;
          else             tmr_inc = 1'b1;
        end
      end
      ST_ERROR: mem_hold = 1'b1;
      default:  state_d  = ST_RUN;
    endcase
  end

  // Outputs are forced low while reset is held, independent of the clock
  always_comb begin
    mem_req  = 1'b0;
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_stall  = 1'b0;
    W_bubble = 1'b0;
    halt     = 1'b0;
    flush    = 1'b0;
    if (rst_n) begin
      mem_req = M_memop && (state_q != ST_ERROR);
      halt    = (state_q == ST_ERROR);
      if (mem_hold) begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        M_stall  = 1'b1;
        W_bubble = 1'b1;
      end else if (E_br_taken) begin
        flush    = 1'b1;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
      end else if (load_use) begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        E_bubble = 1'b1;
      end
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_cnt_q    <= '0;
    end else begin
      if (F_stall) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush)   flush_cnt_q    <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_cnt    = flush_cnt_q;
`else
  logic unused_flush;
  assign unused_flush = flush;
`endif

endmodule
